// File: rtl/ioctl_rom_sender.sv
// ioctl_rom_sender: streams a byte image from a synchronous source memory
// into a core as an ioctl download, one write strobe per byte.
module ioctl_rom_sender #(
    parameter int ADDR_W    = 25,
    parameter int SETUP_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int HOLD_CYC  = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] length,
    input  logic [7:0]        index,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_data,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE, SETUP, FETCH, DATA, WRITE, GAP, HOLD, DONE
    } state_t;

    localparam int SETUP_N = SETUP_CYC - 1;
    localparam int HOLD_N  = HOLD_CYC - 1;
    localparam int GAP_N   = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam logic [ADDR_W-1:0] ONE = 1;

    state_t            state;
    logic [15:0]       tmr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] cnt_nxt;

    // Byte counter after the current strobe
    always_comb begin
        cnt_nxt = cnt + ONE;
    end

    // Strobe is one cycle per byte: WRITE state gated by the receiver stall
    assign ioctl_wr = (state == WRITE) && !ioctl_wait;

    // Download sequencer with registered outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state          <= IDLE;
            tmr            <= '0;
            cnt            <= '0;
            len            <= '0;
            src_rd         <= 1'b0;
            src_addr       <= '0;
            ioctl_download <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_dout     <= '0;
            ioctl_index    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len            <= length;
                        ioctl_index    <= index;
                        cnt            <= '0;
                        tmr            <= 16'(SETUP_N);
                        ioctl_download <= 1'b1;
                        busy           <= 1'b1;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    if (tmr != 16'd0) begin
                        tmr <= tmr - 16'd1;
                    end else if (len == '0) begin
                        tmr   <= 16'(HOLD_N);
                        state <= HOLD;
                    end else begin
                        src_rd   <= 1'b1;
                        src_addr <= cnt;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    src_rd   <= 1'b0;
                    src_addr <= '0;
                    state    <= DATA;
                end
                DATA: begin
                    ioctl_dout <= src_data;
                    ioctl_addr <= cnt;
                    state      <= WRITE;
                end
                WRITE: begin
                    if (!ioctl_wait) begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == len) begin
                            tmr   <= 16'(HOLD_N);
                            state <= HOLD;
                        end else if (GAP_CYC == 0) begin
                            src_rd   <= 1'b1;
                            src_addr <= cnt_nxt;
                            state    <= FETCH;
                        end else begin
                            tmr   <= 16'(GAP_N);
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (tmr != 16'd0) begin
                        tmr <= tmr - 16'd1;
                    end else begin
                        src_rd   <= 1'b1;
                        src_addr <= cnt;
                        state    <= FETCH;
                    end
                end
                HOLD: begin
                    if (tmr != 16'd0) begin
                        tmr <= tmr - 16'd1;
                    end else begin
                        ioctl_download <= 1'b0;
                        done           <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ioctl_rom_sender.sv
// tb_ioctl_rom_sender: timeline model of the download per run, compared
// against the sender every cycle, plus literal strobe/done cycle anchors.
module tb_ioctl_rom_sender;

    localparam int AW = 25;
    localparam int S  = 4;
    localparam int H  = 4;
    localparam int NC = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;
    logic [AW-1:0] length = '0;
    logic [7:0] index = '0;
    logic wt = 1'b0;

    logic start0, start1;
    logic rd0, rd1, dl0, dl1, wr0, wr1;
    logic bz0, bz1, dn0, dn1;
    logic [AW-1:0] sa0, sa1, ia0, ia1;
    logic [7:0] sd0, sd1, do0, do1, ix0, ix1;

    logic o_rd, o_dl, o_wr, o_bz, o_dn;
    logic [AW-1:0] o_sa, o_ia;
    logic [7:0] o_do, o_ix;

    logic [7:0] mem [0:15];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    ioctl_rom_sender #(.ADDR_W(AW), .SETUP_CYC(S),
                       .GAP_CYC(2), .HOLD_CYC(H)) u0 (
        .clk_sys(clk), .reset(reset), .start(start0),
        .length(length), .index(index),
        .src_rd(rd0), .src_addr(sa0), .src_data(sd0),
        .ioctl_download(dl0), .ioctl_wr(wr0),
        .ioctl_addr(ia0), .ioctl_dout(do0),
        .ioctl_index(ix0), .ioctl_wait(wt),
        .busy(bz0), .done(dn0)
    );

    ioctl_rom_sender #(.ADDR_W(AW), .SETUP_CYC(S),
                       .GAP_CYC(0), .HOLD_CYC(H)) u1 (
        .clk_sys(clk), .reset(reset), .start(start1),
        .length(length), .index(index),
        .src_rd(rd1), .src_addr(sa1), .src_data(sd1),
        .ioctl_download(dl1), .ioctl_wr(wr1),
        .ioctl_addr(ia1), .ioctl_dout(do1),
        .ioctl_index(ix1), .ioctl_wait(wt),
        .busy(bz1), .done(dn1)
    );

    // One-cycle-latency source memories
    always @(posedge clk) begin
        if (rd0) sd0 <= mem[sa0[3:0]];
        if (rd1) sd1 <= mem[sa1[3:0]];
    end

    always_comb begin
        o_rd = sel ? rd1 : rd0;
        o_dl = sel ? dl1 : dl0;
        o_wr = sel ? wr1 : wr0;
        o_bz = sel ? bz1 : bz0;
        o_dn = sel ? dn1 : dn0;
        o_sa = sel ? sa1 : sa0;
        o_ia = sel ? ia1 : ia0;
        o_do = sel ? do1 : do0;
        o_ix = sel ? ix1 : ix0;
    end

    function automatic void chk(string nm, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endfunction

    // Expected timeline, indexed by cycle after the accepting edge
    bit e_dl [NC];
    bit e_wr [NC];
    bit e_rd [NC];
    bit e_bz [NC];
    bit e_dn [NC];
    bit e_st [NC];
    bit e_zero [NC];
    int e_sa [NC];
    int e_b [NC];
    bit w_sch [NC];
    bit xs [NC];
    int wr_q [$];
    int m_done;
    int cur_idx;

    task automatic build(input int len, input int g, input int rst_at);
        int t, w;
        for (int c = 0; c < NC; c++) begin
            e_dl[c] = 0; e_wr[c] = 0; e_rd[c] = 0; e_bz[c] = 0;
            e_dn[c] = 0; e_st[c] = 0; e_zero[c] = 0;
            e_sa[c] = 0; e_b[c] = 0;
        end
        wr_q.delete();
        for (int c = 1; c <= S; c++) begin
            e_dl[c] = 1; e_bz[c] = 1;
        end
        w = S;
        t = S + 1;
        for (int b = 0; b < len; b++) begin
            e_rd[t] = 1; e_sa[t] = b;
            e_dl[t] = 1; e_bz[t] = 1;
            e_dl[t+1] = 1; e_bz[t+1] = 1;
            w = t + 2;
            while (w < NC - 20 && w_sch[w]) begin
                e_st[w] = 1; e_b[w] = b;
                e_dl[w] = 1; e_bz[w] = 1;
                w++;
            end
            e_wr[w] = 1; e_b[w] = b;
            e_dl[w] = 1; e_bz[w] = 1;
            wr_q.push_back(w);
            if (b != len - 1) begin
                for (int c = w + 1; c <= w + g; c++) begin
                    e_dl[c] = 1; e_bz[c] = 1;
                end
            end
            t = w + 1 + g;
        end
        for (int c = w + 1; c <= w + H; c++) begin
            e_dl[c] = 1; e_bz[c] = 1;
        end
        m_done = w + H + 1;
        e_dn[m_done] = 1;
        e_bz[m_done] = 1;
        if (rst_at >= 0) begin
            for (int c = rst_at + 1; c < NC; c++) begin
                e_dl[c] = 0; e_wr[c] = 0; e_rd[c] = 0; e_bz[c] = 0;
                e_dn[c] = 0; e_st[c] = 0; e_zero[c] = 1;
            end
            while (wr_q.size() > 0 && wr_q[wr_q.size()-1] > rst_at)
                void'(wr_q.pop_back());
            if (m_done > rst_at) m_done = -1;
        end
    endtask

    int cyc;
    bit active = 0;
    int obs_q [$];
    int obs_done;
    int obs_rd;

    // Per-cycle comparison of the selected sender against the timeline
    always @(negedge clk) begin
        if (active) begin
            chk($sformatf("download@%0d", cyc), 32'(o_dl), 32'(e_dl[cyc]));
            chk($sformatf("wr@%0d", cyc), 32'(o_wr), 32'(e_wr[cyc]));
            chk($sformatf("src_rd@%0d", cyc), 32'(o_rd), 32'(e_rd[cyc]));
            chk($sformatf("busy@%0d", cyc), 32'(o_bz), 32'(e_bz[cyc]));
            chk($sformatf("done@%0d", cyc), 32'(o_dn), 32'(e_dn[cyc]));
            if (e_rd[cyc])
                chk($sformatf("src_addr@%0d", cyc), 32'(o_sa), e_sa[cyc]);
            if (e_wr[cyc] || e_st[cyc]) begin
                chk($sformatf("addr@%0d", cyc), 32'(o_ia), e_b[cyc]);
                chk($sformatf("dout@%0d", cyc), 32'(o_do),
                    32'(mem[e_b[cyc]]));
            end
            if (e_dl[cyc])
                chk($sformatf("index@%0d", cyc), 32'(o_ix), cur_idx);
            if (e_zero[cyc]) begin
                chk($sformatf("rst_addr@%0d", cyc), 32'(o_ia), 0);
                chk($sformatf("rst_dout@%0d", cyc), 32'(o_do), 0);
                chk($sformatf("rst_index@%0d", cyc), 32'(o_ix), 0);
                chk($sformatf("rst_saddr@%0d", cyc), 32'(o_sa), 0);
            end
            if (o_wr) obs_q.push_back(cyc);
            if (o_rd) obs_rd++;
            if (o_dn) obs_done = cyc;
        end
    end

    task automatic run(input int len, input int idx, input bit s,
                       input int rst_at, input int n);
        sel = s;
        cur_idx = idx;
        build(len, s ? 0 : 2, rst_at);
        obs_q.delete();
        obs_done = -1;
        obs_rd = 0;
        @(posedge clk); #1;
        length = AW'(len);
        index = 8'(idx);
        cyc = 0;
        active = 1;
        for (int c = 0; c < n; c++) begin
            cyc = c;
            start = (c == 0) || xs[c];
            reset = (c == rst_at);
            wt = w_sch[c];
            @(posedge clk); #1;
        end
        active = 0;
        start = 0;
        reset = 0;
        wt = 0;
    endtask

    task automatic clear_sched();
        for (int c = 0; c < NC; c++) begin
            w_sch[c] = 0; xs[c] = 0;
        end
    endtask

    task automatic pin(string nm, input int exp_w[$], input int exp_d);
        chk({nm, "_model_nwr"}, wr_q.size(), exp_w.size());
        chk({nm, "_dut_nwr"}, obs_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size(); i++) begin
            if (i < wr_q.size())
                chk($sformatf("%s_model_wr%0d", nm, i), wr_q[i], exp_w[i]);
            if (i < obs_q.size())
                chk($sformatf("%s_dut_wr%0d", nm, i), obs_q[i], exp_w[i]);
        end
        chk({nm, "_model_done"}, m_done, exp_d);
        chk({nm, "_dut_done"}, obs_done, exp_d);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h11 * i);
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
        clear_sched();
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dl0", 32'(dl0), 0);
        chk("rst_wr0", 32'(wr0), 0);
        chk("rst_rd0", 32'(rd0), 0);
        chk("rst_busy0", 32'(bz0), 0);
        chk("rst_done0", 32'(dn0), 0);
        chk("rst_addr0", 32'(ia0), 0);
        chk("rst_dout0", 32'(do0), 0);
        chk("rst_index0", 32'(ix0), 0);
        chk("rst_saddr0", 32'(sa0), 0);
        chk("rst_dl1", 32'(dl1), 0);
        chk("rst_busy1", 32'(bz1), 0);
        reset = 0;

        // Basic three-byte image
        run(3, 8'h05, 0, -1, 25);
        pin("basic", '{7, 12, 17}, 22);
        chk("basic_nrd", obs_rd, 3);

        // Receiver stall during second write
        clear_sched();
        for (int c = 12; c <= 15; c++) w_sch[c] = 1;
        run(3, 8'h05, 0, -1, 29);
        pin("stall", '{7, 16, 21}, 26);

        // Empty image
        clear_sched();
        run(0, 8'h3C, 0, -1, 12);
        pin("empty", '{}, 9);
        chk("empty_nrd", obs_rd, 0);

        // Extra start pulses are ignored, including in DONE
        clear_sched();
        xs[5] = 1;
        xs[22] = 1;
        run(3, 8'h07, 0, -1, 26);
        pin("restart", '{7, 12, 17}, 22);

        // Reset in mid-transfer, then a clean restart
        clear_sched();
        run(3, 8'h09, 0, 13, 20);
        pin("reset", '{7, 12}, -1);
        clear_sched();
        run(3, 8'h0A, 0, -1, 25);
        pin("after_rst", '{7, 12, 17}, 22);

        // Back-to-back bytes with no gap
        clear_sched();
        run(4, 8'h21, 1, -1, 25);
        pin("nogap", '{7, 10, 13, 16}, 21);
        chk("nogap_nrd", obs_rd, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ioctl_rom_sender.md
# ioctl_rom_sender

Initiator side of the ioctl download interface consumed by the `top` simulation harness and the `centipede` core. Streams a byte image from a synchronous source memory into the core as an ioctl download: it raises `ioctl_download`, issues one `ioctl_wr` strobe per byte with `ioctl_addr`/`ioctl_dout`/`ioctl_index`, and honours `ioctl_wait`. It lets RTL-only benches and on-chip loaders deliver ROMs without a host.

## Interface
- `ADDR_W`, 25: width of `ioctl_addr`, `src_addr` and `length`.
- `SETUP_CYC`, 4: cycles `ioctl_download` is high before the first fetch; minimum 1.
- `GAP_CYC`, 2: idle cycles after each write; 0 is legal.
- `HOLD_CYC`, 4: cycles `ioctl_download` stays high after the last write; minimum 1.

Ports:
- `clk_sys` in 1: only clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request; accepted only in IDLE.
- `length` in ADDR_W: byte count, latched at accept.
- `index` in 8: image index, latched at accept.
- `src_rd` out 1: source read strobe.
- `src_addr` out ADDR_W: source byte address.
- `src_data` in 8: source data, valid the cycle after `src_rd`.
- `ioctl_download` out 1: download window.
- `ioctl_wr` out 1: per-byte write strobe.
- `ioctl_addr` out ADDR_W: byte offset.
- `ioctl_dout` out 8: byte value.
- `ioctl_index` out 8: latched index.
- `ioctl_wait` in 1: receiver stall request.
- `busy` out 1: high from IDLE exit through the DONE cycle inclusive.
- `done` out 1: one-cycle pulse at completion.

## Operation
- States: IDLE, SETUP, FETCH, DATA, WRITE, GAP, HOLD, DONE.
- IDLE: all outputs 0. On `start`, latch `length` and `index`, clear byte counter `cnt`, and go to SETUP.
- SETUP: `ioctl_download`=1 and `ioctl_index` valid. Lasts SETUP_CYC cycles, then goes to FETCH, or to HOLD if `length`=0.
- FETCH, 1 cycle: `src_rd`=1, `src_addr`=`cnt`.
- DATA, 1 cycle: capture `src_data` into `ioctl_dout` and load `ioctl_addr`=`cnt`. Both are registered and stable from WRITE entry until the next DATA.
- WRITE:
  - `ioctl_wr` = in WRITE AND NOT `ioctl_wait`. It is combinational from the registered state flag, so it is always exactly one cycle per byte.
  - While `ioctl_wait`=1, stay in WRITE with addr/dout held; the stall length is unbounded.
  - In the strobe cycle, `cnt`←`cnt`+1. If the new `cnt`=`length`, go to HOLD; otherwise go to GAP, or straight to FETCH if GAP_CYC=0.
- GAP: GAP_CYC cycles, then FETCH. `ioctl_wait` is ignored outside WRITE.
- HOLD: HOLD_CYC cycles with `ioctl_download`=1 and `ioctl_wr`=0, then DONE.
- DONE, 1 cycle: `ioctl_download`=0, `done`=1, `busy`=1. Then IDLE.
- `ioctl_index` holds its value until the next accept. `ioctl_addr`/`ioctl_dout` hold their last values after completion.
- `start` outside IDLE is ignored, including in the DONE cycle.
- `cnt` compares at full ADDR_W width, which allows lengths up to 2^ADDR_W−1. No wrap is possible.
- Reset in any state: next cycle is IDLE with every output 0. No `done` pulse and no further `ioctl_wr`.

## Timing
- Reset values: `src_rd`, `src_addr`, `ioctl_download`, `ioctl_wr`, `ioctl_addr`, `ioctl_dout`, `ioctl_index`, `busy` and `done` are all 0.
- Cycle numbering: `start` is sampled at cycle 0.
  - Cycle 1: `ioctl_download` and `busy` rise.
  - Cycle SETUP_CYC+1: first `src_rd`.
  - Cycle SETUP_CYC+3: first `ioctl_wr`, if no wait.
- Byte period without stalls is 3+GAP_CYC cycles. Each `ioctl_wait` cycle in WRITE adds one cycle.
- Last write at cycle W → `done` and `ioctl_download` fall at cycle W+HOLD_CYC+1 → `busy` low at W+HOLD_CYC+2.
- `length`=0 → `done` at cycle SETUP_CYC+HOLD_CYC+1, with zero `ioctl_wr` and zero `src_rd`.
- Source contract: read latency is exactly 1 cycle. `src_rd` is high for exactly one cycle per byte, with no speculative reads.

## Test plan
- Defaults, `length`=3, `index`=0x05, source bytes AA/BB/CC → `ioctl_wr` at cycles 7, 12, 17 with addr 0/1/2, dout AA/BB/CC, index 05; `done` at 22; `busy` low at 23.
- Same stimulus, `ioctl_wait` high for cycles 12–15 → second strobe at cycle 16 with addr 1, dout BB held through the stall; third strobe at 21; `done` at 26.
- `length`=0 → `ioctl_download` high for cycles 1–8, `done` at 9, no `src_rd` and no `ioctl_wr`.
- `start` pulsed again at cycles 5 and 22 of a `length`=3 run → ignored; exactly 3 strobes; state returns to IDLE at 23.
- `reset` asserted at cycle 13 of a `length`=3 run → from cycle 14 all outputs 0 and no `done`. A fresh `start` then restarts from addr 0.
- GAP_CYC=0, `length`=4 → strobes 3 cycles apart (7, 10, 13, 16); `src_addr` sequence 0–3; one `src_rd` per byte.
